priority_arb_n_v: RTL

Parametrised, registered successor to the 4-to-2 priority encoder. Samples an N-bit request vector and issues one granted index at a time, with `o_code`/`o_valid` held stable until the consumer acknowledges. Arbitration is either fixed priority (MSB highest) or round-robin. Sits between a group of requesters and a single shared resource in the datapath.

---
 rtl/priority_arb_n_v.sv | 132 +++++++++++++
 1 files changed

// File: rtl/priority_arb_n_v.sv
// rtl/priority_arb_n_v.sv - registered N-way request arbiter, fixed priority or round-robin
// Optional round-robin mode and last-grant pointer are compiled in with PRIORITY_ARB_RR_EN.
module priority_arb_n_v #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_code,
    input  logic             i_rr,
    input  logic             i_ack,
    output logic [IDX_W-1:0] o_code,
    output logic [N_REQ-1:0] o_onehot,
    output logic             o_valid
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [IDX_W-1:0] code_q, code_d;
    logic [N_REQ-1:0] onehot_q, onehot_d;
    logic [IDX_W-1:0] fixed_idx;
    logic [IDX_W-1:0] win_idx;
    logic [N_REQ-1:0] fixed_sh;

    // Ascending scan so the highest set bit is the last to overwrite.
    always_comb begin
        fixed_idx = '0;
        fixed_sh  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            fixed_sh = i_code >> k;
            if (fixed_sh[0]) begin
                fixed_idx = IDX_W'(k);
            end
        end
    end

`ifdef PRIORITY_ARB_RR_EN
    logic [IDX_W-1:0] lg_q, lg_d;
    logic [IDX_W-1:0] rr_idx;
    logic [N_REQ-1:0] rr_sh;
    int               rr_pos;

    // Offsets scanned far-to-near so the position just below lg overwrites last;
    // lg itself (offset N_REQ) is the weakest candidate.
    always_comb begin
        rr_idx = '0;
        rr_sh  = '0;
        rr_pos = 0;
        for (int off = N_REQ; off >= 1; off--) begin
            rr_pos = int'(lg_q) - off;
            if (rr_pos < 0) begin
                rr_pos = rr_pos + N_REQ;
            end
            rr_sh = i_code >> rr_pos;
            if (rr_sh[0]) begin
                rr_idx = IDX_W'(rr_pos);
            end
        end
    end

    always_comb begin
        win_idx = i_rr ? rr_idx : fixed_idx;
    end
`else
    logic unused_rr;
    assign unused_rr = i_rr;

    always_comb begin
        win_idx = fixed_idx;
    end
`endif

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        onehot_d = onehot_q;
`ifdef PRIORITY_ARB_RR_EN
        lg_d     = lg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|i_code) begin
                    code_d   = win_idx;
                    onehot_d = ONE << win_idx;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (i_ack) begin
                    onehot_d = '0;
                    state_d  = ST_IDLE;
`ifdef PRIORITY_ARB_RR_EN
                    lg_d     = code_q;
`endif
                end
            end
            default: begin
                state_d  = ST_IDLE;
                onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            onehot_q <= '0;
`ifdef PRIORITY_ARB_RR_EN
            lg_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            onehot_q <= onehot_d;
`ifdef PRIORITY_ARB_RR_EN
            lg_q     <= lg_d;
`endif
        end
    end

    assign o_code   = code_q;
    assign o_onehot = onehot_q;
    assign o_valid  = (state_q == ST_GRANT);

endmodule
